tc_slot_arbiter: RTL

- Shares one 7-bit period down-counter (count7 semantics: load P, count to 0, tc at 0) between NREQ requesters.
- Each requester asks for one timed interval of its own period. The block arbitrates round-robin, loads that period, runs the counter and returns a one-cycle done pulse to the winner.
- Sits between the divider/toggle datapaths and firmware-configured period registers, so a single counter resource serves several timing channels.

---
 rtl/tc_slot_arbiter.sv | 101 ++++++++++
 1 files changed

// File: rtl/tc_slot_arbiter.sv
// Round-robin arbiter that lends one shared period down-counter to NREQ requesters.
// Latency: grant one edge after request; grant/busy held P+1 cycles; done pulses on the edge that clears grant.
// Backpressure: requesters hold req until done; dropping req aborts the interval without a done pulse.
module tc_slot_arbiter #(
    parameter int NREQ     = 4,
    parameter int PERIOD_W = 7
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ*PERIOD_W-1:0]   period,
    output logic [NREQ-1:0]            grant,
    output logic [NREQ-1:0]            done,
    output logic                       busy,
    output logic [PERIOD_W-1:0]        count,
    output logic                       tc
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t          state;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   owner_nxt;
    logic [IW-1:0]   pick_idx;
    logic            pick_vld;

    // First requester at or after rr_ptr, ascending with wrap; descending scan so the nearest one wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[(int'(rr_ptr) + k) % NREQ]) begin
                pick_vld = 1'b1;
                pick_idx = IW'((int'(rr_ptr) + k) % NREQ);
            end
        end
    end

    // Pointer value after the current owner releases the counter.
    always_comb begin
        owner_nxt = (int'(owner) == NREQ - 1) ? '0 : owner + IW'(1);
    end

    // Terminal count is only meaningful while an interval is running.
    always_comb begin
        tc = (state == RUN) && (count == '0);
    end

    // Arbitration, counter load/decrement and release; done is a one-edge pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            grant  <= '0;
            done   <= '0;
            busy   <= 1'b0;
            count  <= '0;
            rr_ptr <= '0;
            owner  <= '0;
        end else begin
            done <= '0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        grant <= {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
                        count <= period[pick_idx*PERIOD_W +: PERIOD_W];
                        owner <= pick_idx;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    // Abort wins over terminal count so an abandoned request never sees done.
                    if (!req[owner]) begin
                        grant  <= '0;
                        busy   <= 1'b0;
                        rr_ptr <= owner_nxt;
                        state  <= IDLE;
                    end else if (count == '0) begin
                        done   <= grant;
                        grant  <= '0;
                        busy   <= 1'b0;
                        rr_ptr <= owner_nxt;
                        state  <= IDLE;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
